instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Instruction-memory responder: the slave end of the core's instruction-fetch request/grant interface. Accepts one fetch request at a time, returns grant, then delivers the 32-bit instruction word after a fixed programmable latency with a one-cycle valid strobe. Sits between the core's fetch stage and the word-addressed instruction storage. Provides a bench-side load port for program preload.

## Interface

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, 2..4096
- LATENCY, 2, cycles from grant edge to response; 1..7

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- instr_req_ip  in  1  request valid; requester holds req and address stable until granted
- instr_addr_ip  in  32  byte address of instruction
- instr_gnt_op  out  1  request accepted this cycle (combinational)
- instr_rvalid_op  out  1  response valid, one-cycle pulse
- instr_rdata_op  out  32  instruction word; valid only with rvalid
- instr_err_op  out  1  response is an error; valid only with rvalid
- load_en_ip  in  1  preload write strobe
- load_addr_ip  in  $clog2(DEPTH)  preload word index
- load_data_ip  in  32  preload data

## Operation

- States: IDLE, WAIT, RESP.
- instr_gnt_op = instr_req_ip && (state == IDLE); see Configuration for RESP.
- Handshake: request accepted on the posedge where req && gnt. Address latched at that edge.
- On accept: if LATENCY == 1, next state RESP; else WAIT with counter <= LATENCY-1.
- WAIT: counter decrements each cycle; at counter == 1, next state RESP.
- RESP: instr_rvalid_op = 1 for exactly one cycle; next state IDLE (or per Configuration).
- Data and error are registered on the edge entering RESP, from the latched address:
  - Error when addr[1:0] != 0 (misaligned) or addr[31:2] >= DEPTH (out of range): instr_err_op = 1, instr_rdata_op = 32'h0000_0000.
  - Otherwise instr_err_op = 0, instr_rdata_op = mem[addr[31:2]].
- Load port: mem[load_addr_ip] <= load_data_ip on any posedge with load_en_ip, in every state, including during reset.
- Load and read of the same word on the same edge: read returns the old contents.
- Counter width: 3 bits; no wrap possible within 1..7.

## Timing

- Reset values: state IDLE, counter 0, instr_rvalid_op 0, instr_rdata_op 0, instr_err_op 0. instr_gnt_op follows instr_req_ip after reset (IDLE). Memory contents are not cleared.
- Reset mid-operation (WAIT or RESP): pending response discarded, no rvalid emitted after the reset edge.
- Latency: request granted in cycle T -> rvalid high in cycle T+LATENCY.
- Non-pipelined throughput: one response per LATENCY+1 cycles with req held high.
- Requests arriving while state != IDLE are not granted and not lost; the requester keeps req asserted.
- rvalid never asserts in two consecutive cycles unless back-to-back mode is enabled and LATENCY == 1.

## Configuration

- Macro INSTR_MEM_BACK_TO_BACK_EN.
- Defined: gnt also asserts in RESP (instr_gnt_op = instr_req_ip && (state == IDLE || state == RESP)). An accept in RESP transitions directly to WAIT/RESP per LATENCY, as from IDLE. Throughput one response per LATENCY cycles; with LATENCY == 1 rvalid can stay high on consecutive cycles.
- Undefined: grant only in IDLE; RESP always returns to IDLE.

## Test plan

- Reset, preload mem[0..3] = 32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213, LATENCY=2; req addr 0x0 in cycle T -> gnt in T, rvalid with rdata 32'h0000_0093, err 0 in T+2.
- req held high, addr stepping 0x0, 0x4, 0x8 on each grant, macro undefined -> grants spaced 3 cycles apart, rdata in order, no rvalid gaps violated.
- req addr 0x6 -> rvalid with err 1, rdata 0; req addr 0x400 (DEPTH=256) -> err 1, rdata 0.
- Grant addr 0x8, assert reset while in WAIT -> no rvalid afterwards; outputs 0; next req granted immediately in IDLE.
- load_en_ip writes mem[2] = 32'hDEAD_BEEF on the same edge RESP is entered for addr 0x8 -> rdata is the old value; a following fetch of 0x8 returns 32'hDEAD_BEEF.
- INSTR_MEM_BACK_TO_BACK_EN defined, LATENCY=1, req held high -> gnt and rvalid high every cycle after the first, rdata tracks successive words.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: slave end of the instruction-fetch request/grant
// interface. Grants one request at a time, returns the addressed 32-bit word
// (or an error) after LATENCY cycles with a one-cycle rvalid strobe.
// A preload port writes storage in any state, including during reset.
// Optional feature macro: INSTR_MEM_BACK_TO_BACK_EN (grant also in RESP).
module instr_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     instr_req_ip,
    input  logic [31:0]              instr_addr_ip,
    output logic                     instr_gnt_op,
    output logic                     instr_rvalid_op,
    output logic [31:0]              instr_rdata_op,
    output logic                     instr_err_op,
    input  logic                     load_en_ip,
    input  logic [$clog2(DEPTH)-1:0] load_addr_ip,
    input  logic [31:0]              load_data_ip
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    state_t      accept_target;
    logic [2:0]  cnt;
    logic        accept;
    logic [31:0] addr_p0;
    logic [31:0] rd_addr;
    logic        rd_err;
    logic [31:0] rdata_p1;
    logic        err_p1;
    logic        vld_p1;

    logic [31:0] mem [DEPTH];

    // Misaligned byte address or word index beyond the stored depth
    function automatic logic fetch_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

`ifdef INSTR_MEM_BACK_TO_BACK_EN
    assign instr_gnt_op = instr_req_ip && ((state == IDLE) || (state == RESP));
`else
    assign instr_gnt_op = instr_req_ip && (state == IDLE);
`endif

    assign accept        = instr_gnt_op;
    assign accept_target = (LATENCY == 1) ? RESP : WAIT;

    // With a one-cycle latency the response is read on the accept edge itself,
    // before the address latch has captured anything, so use the live address.
    assign rd_addr = (LATENCY == 1) ? instr_addr_ip : addr_p0;
    assign rd_err  = fetch_err(rd_addr);

    // Next-state decode for the request/wait/response sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = accept_target;
            end
            WAIT: begin
                if (cnt == 3'd1) state_nx = RESP;
            end
            RESP: begin
`ifdef INSTR_MEM_BACK_TO_BACK_EN
                state_nx = accept ? accept_target : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and latency down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            if (accept && (LATENCY > 1)) begin
                cnt <= 3'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Capture the request address on the accept edge
    always_ff @(posedge clock) begin
        if (accept) addr_p0 <= instr_addr_ip;
    end

    // Preload write port, active regardless of reset or state
    always_ff @(posedge clock) begin
        if (load_en_ip) mem[load_addr_ip] <= load_data_ip;
    end

    // ---- response stage: registered on the edge entering RESP ----
    // Response registers; a same-edge preload write is not visible here
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= 32'h0000_0000;
            err_p1   <= 1'b0;
        end else begin
            vld_p1 <= (state_nx == RESP);
            if (state_nx == RESP) begin
                err_p1   <= rd_err;
                rdata_p1 <= rd_err ? 32'h0000_0000 : mem[rd_addr[AW+1:2]];
            end
        end
    end

    assign instr_rvalid_op = vld_p1;
    assign instr_rdata_op  = rdata_p1;
    assign instr_err_op    = err_p1;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH=256, LATENCY=2). When built
// with INSTR_MEM_BACK_TO_BACK_EN a second LATENCY=1 instance is exercised.
module tb_instr_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [4];

`ifdef INSTR_MEM_BACK_TO_BACK_EN
    localparam int PER = 2;
`else
    localparam int PER = 3;
`endif

    always #5 clock = ~clock;

    instr_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .instr_req_ip    (req),
        .instr_addr_ip   (addr),
        .instr_gnt_op    (gnt),
        .instr_rvalid_op (rvalid),
        .instr_rdata_op  (rdata),
        .instr_err_op    (err),
        .load_en_ip      (load_en),
        .load_addr_ip    (load_addr),
        .load_data_ip    (load_data)
    );

`ifdef INSTR_MEM_BACK_TO_BACK_EN
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        err2;

    instr_mem_responder #(.DEPTH(256), .LATENCY(1)) dut2 (
        .clock           (clock),
        .reset           (reset),
        .instr_req_ip    (req2),
        .instr_addr_ip   (addr2),
        .instr_gnt_op    (gnt2),
        .instr_rvalid_op (rvalid2),
        .instr_rdata_op  (rdata2),
        .instr_err_op    (err2),
        .load_en_ip      (load_en),
        .load_addr_ip    (load_addr),
        .load_data_ip    (load_data)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the active edge
    task automatic drive_pt();
        @(posedge clock);
        #1;
    endtask

    // One LATENCY=2 fetch with req dropped after grant; optional preload of
    // word 2 on the edge that enters RESP.
    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e,
                         input bit ld, input logic [31:0] ld_d);
        req  = 1'b1;
        addr = a;
        @(negedge clock);
        chk({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
        drive_pt();
        req = 1'b0;
        if (ld) begin
            load_en   = 1'b1;
            load_addr = 8'd2;
            load_data = ld_d;
        end
        @(negedge clock);
        chk({tag, "_wait_rvalid"}, {31'b0, rvalid}, 32'd0);
        drive_pt();
        load_en = 1'b0;
        @(negedge clock);
        chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_e});
        drive_pt();
        @(negedge clock);
        chk({tag, "_rvalid_off"}, {31'b0, rvalid}, 32'd0);
        drive_pt();
    endtask

    initial begin
        int ngnt;
        bit exp_g;
        bit exp_v;

        words[0] = 32'h0000_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_0193;
        words[3] = 32'h0030_0213;

        reset     = 1'b1;
        req       = 1'b0;
        addr      = 32'h0;
        load_en   = 1'b0;
        load_addr = 8'd0;
        load_data = 32'h0;
`ifdef INSTR_MEM_BACK_TO_BACK_EN
        req2  = 1'b0;
        addr2 = 32'h0;
`endif
        drive_pt();

        // Preload during reset
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = words[i];
            drive_pt();
        end
        load_en = 1'b0;

        @(negedge clock);
        chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_gnt_noreq", {31'b0, gnt}, 32'd0);
        drive_pt();
        reset = 1'b0;

        // Single fetch of word 0, rvalid two cycles after grant
        fetch("f0", 32'h0, 32'h0000_0093, 1'b0, 1'b0, 32'h0);

        // Held request, address stepped on each grant
        req  = 1'b1;
        addr = 32'h0;
        ngnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            exp_g = ((c % PER) == 0) && ((c / PER) < 3);
            exp_v = (c >= 2) && (((c - 2) % PER) == 0) && (((c - 2) / PER) < 3);
            chk($sformatf("stream_gnt_c%0d", c), {31'b0, gnt}, {31'b0, exp_g});
            chk($sformatf("stream_rvalid_c%0d", c), {31'b0, rvalid}, {31'b0, exp_v});
            if (exp_v) chk($sformatf("stream_rdata_c%0d", c), rdata, words[(c - 2) / PER]);
            if (gnt) ngnt++;
            drive_pt();
            if (gnt) addr = addr + 32'd4;
            if (ngnt >= 3) req = 1'b0;
        end

        // Error responses: misaligned and out of range
        fetch("mis", 32'h6, 32'h0, 1'b1, 1'b0, 32'h0);
        fetch("oor", 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);

        // Leave non-zero rdata, then reset while in WAIT
        fetch("f1", 32'h4, 32'h0010_0113, 1'b0, 1'b0, 32'h0);
        req  = 1'b1;
        addr = 32'h8;
        @(negedge clock);
        chk("rst_gnt", {31'b0, gnt}, 32'd1);
        drive_pt();
        req   = 1'b0;
        reset = 1'b1;
        drive_pt();
        reset = 1'b0;
        req   = 1'b1;
        addr  = 32'hC;
        @(negedge clock);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_regnt", {31'b0, gnt}, 32'd1);
        drive_pt();
        req = 1'b0;
        @(negedge clock);
        chk("rst_rvalid2", {31'b0, rvalid}, 32'd0);
        drive_pt();
        @(negedge clock);
        chk("rst_f3_rvalid", {31'b0, rvalid}, 32'd1);
        chk("rst_f3_rdata", rdata, 32'h0030_0213);
        drive_pt();

        // Preload of word 2 on the RESP-entry edge returns old data, then new
        fetch("ld_old", 32'h8, 32'h0020_0193, 1'b0, 1'b1, 32'hDEAD_BEEF);
        fetch("ld_new", 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

`ifdef INSTR_MEM_BACK_TO_BACK_EN
        // LATENCY=1 back-to-back: grant and rvalid every cycle
        words[2] = 32'hDEAD_BEEF;
        req2  = 1'b1;
        addr2 = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("b2b_gnt_c%0d", c), {31'b0, gnt2}, {31'b0, (c < 4)});
            chk($sformatf("b2b_rvalid_c%0d", c), {31'b0, rvalid2},
                {31'b0, (c >= 1) && (c <= 4)});
            if ((c >= 1) && (c <= 4)) chk($sformatf("b2b_rdata_c%0d", c), rdata2, words[c - 1]);
            drive_pt();
            addr2 = addr2 + 32'd4;
            if (c >= 3) req2 = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
